// File: rtl/nibble_serial_add_ctrl_if.sv
// nibble_serial_add_ctrl_if
//   Bundles the requester handshake, the result outputs and the external 4-bit CLA slice
//   connection of nibble_serial_add_ctrl.
//   Requester -> ctrl : start, sub, a_in[W], b_in[W]
//   ctrl -> requester : busy, done, result[W], cout, ovf, zero
//   ctrl -> slice     : slice_x[4], slice_y[4], slice_c0
//   slice -> ctrl     : slice_s[4], slice_gp, slice_pp
//   The master side owns the requester signals and also hosts the CLA slice.
interface nibble_serial_add_ctrl_if #(
    parameter int unsigned NIBBLES = 8
);
    localparam int unsigned W = 4 * NIBBLES;

    logic         start;
    logic         sub;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [3:0]   slice_x;
    logic [3:0]   slice_y;
    logic         slice_c0;
    logic [3:0]   slice_s;
    logic         slice_gp;
    logic         slice_pp;

    modport master (
        output start, sub, a_in, b_in, slice_s, slice_gp, slice_pp,
        input  busy, done, result, cout, ovf, zero, slice_x, slice_y, slice_c0
    );

    modport slave (
        input  start, sub, a_in, b_in, slice_s, slice_gp, slice_pp,
        output busy, done, result, cout, ovf, zero, slice_x, slice_y, slice_c0
    );
endinterface

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl
//   Serial W-bit add/subtract built around an external combinational 4-bit CLA slice.
//   One nibble is processed per clock, least significant first; the group generate and
//   propagate from the slice form the ripple carry between passes.
//   Ports:
//     clock   : rising-edge clock for all state
//     clear_n : asynchronous active-low reset
//     bus     : slave modport of nibble_serial_add_ctrl_if (handshake, results, slice link)
module nibble_serial_add_ctrl #(
    parameter int unsigned NIBBLES = 8
) (
    input logic                    clock,
    input logic                    clear_n,
    nibble_serial_add_ctrl_if.slave bus
);
    localparam int unsigned W    = 4 * NIBBLES;
    localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    bop_q, bop_d;
    logic [W-1:0]    result_q, result_d;
    logic            cout_q, cout_d;
    logic            ovf_q, ovf_d;
    logic            zero_q, zero_d;

    logic [3:0]      slice_x, slice_y;
    logic            slice_c0;
    logic [IdxW+1:0] nib_lo;

    // Bit offset of the current nibble.
    assign nib_lo = {idx_q, 2'b00};

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        bop_d    = bop_q;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        slice_x  = 4'h0;
        slice_y  = 4'h0;
        slice_c0 = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    // Subtraction is A + ~B + 1, so the sub flag survives only as the
                    // inverted operand and the initial carry.
                    a_d     = bus.a_in;
                    bop_d   = bus.sub ? ~bus.b_in : bus.b_in;
                    carry_d = bus.sub;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                slice_x  = a_q[nib_lo +: 4];
                slice_y  = bop_q[nib_lo +: 4];
                slice_c0 = carry_q;
                result_d[nib_lo +: 4] = bus.slice_s;
                carry_d  = bus.slice_gp | (bus.slice_pp & carry_q);
                if (idx_q == LastIdx) begin
                    idx_d   = '0;
                    state_d = StDone;
                    cout_d  = carry_d;
                    ovf_d   = (a_q[W-1] == bop_q[W-1]) & (result_d[W-1] != a_q[W-1]);
                    zero_d  = (result_d == '0);
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            bop_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            bop_q    <= bop_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.done     = (state_q == StDone);
    assign bus.result   = result_q;
    assign bus.cout     = cout_q;
    assign bus.ovf      = ovf_q;
    assign bus.zero     = zero_q;
    assign bus.slice_x  = slice_x;
    assign bus.slice_y  = slice_y;
    assign bus.slice_c0 = slice_c0;
endmodule

// File: doc/nibble_serial_add_ctrl.md
NIBBLE_SERIAL_ADD_CTRL -- requirements
Module: nibble_serial_add_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 8, giving the number of 4-bit passes per operation; the operand width W is 4*NIBBLES.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clock  in  1  rising-edge clock for all state.
REQ-004 clear_n  in  1  asynchronous active-low reset.
REQ-005 start  in  1  operation request, sampled only in IDLE.
REQ-006 sub  in  1  0 = A+B, 1 = A-B; sampled with start.
REQ-007 a_in  in  W  operand A; sampled with start.
REQ-008 b_in  in  W  operand B; sampled with start.
REQ-009 busy  out  1  high while in RUN.
REQ-010 done  out  1  one-cycle completion pulse.
REQ-011 result  out  W  sum/difference register.
REQ-012 cout  out  1  final carry out (1 = no borrow for sub).
REQ-013 ovf  out  1  two's-complement overflow.
REQ-014 zero  out  1  result == 0.
REQ-015 slice_x  out  4  nibble of A driven to the external 4-bit CLA slice.
REQ-016 slice_y  out  4  nibble of B (or ~B) driven to the slice.
REQ-017 slice_c0  out  1  carry-in driven to the slice.
REQ-018 slice_s  in  4  slice sum, combinational from slice_x/slice_y/slice_c0.
REQ-019 slice_gp  in  1  slice group generate.
REQ-020 slice_pp  in  1  slice group propagate.

Function
REQ-021 The FSM SHALL have the states IDLE, RUN and DONE.
REQ-022 IDLE->RUN on start=1: latch A=a_in and Bop=(sub ? ~b_in : b_in), latch carry=sub, latch the sub flag, set nibble index idx=0.
REQ-023 In RUN, slice_x SHALL equal A[4*idx+3:4*idx], slice_y SHALL equal Bop[4*idx+3:4*idx] and slice_c0 SHALL equal carry, all combinationally from registers.
REQ-024 Each RUN edge SHALL write slice_s into result[4*idx+3:4*idx], set carry <= slice_gp | (slice_pp & carry), and increment idx.
REQ-025 RUN->DONE on the edge that processes idx==NIBBLES-1; idx SHALL never exceed NIBBLES-1 and SHALL wrap to 0 on leaving RUN.
REQ-026 On the RUN->DONE edge: cout <= final carry; ovf <= (A[W-1]==Bop[W-1]) & (new result[W-1] != A[W-1]); zero <= (new result == 0).
REQ-027 DONE SHALL assert done for exactly one cycle and return unconditionally to IDLE.
REQ-028 Latency: with start sampled at edge k, done SHALL be high in the cycle following edge k+NIBBLES (NIBBLES+1 cycles after acceptance).
REQ-029 start SHALL be ignored in RUN and DONE; operand and sub changes during RUN SHALL have no effect.
REQ-030 With start held high continuously, operations SHALL be accepted every NIBBLES+2 cycles.
REQ-031 result SHALL be updated nibble-by-nibble during RUN; cout, ovf and zero SHALL change only on the RUN->DONE edge; all SHALL hold until the next operation completes.
REQ-032 Outside RUN, slice_x, slice_y and slice_c0 SHALL be driven to 0.
REQ-033 busy SHALL be high exactly in RUN; busy and done SHALL never be high together.

Reset
REQ-034 clear_n=0 SHALL immediately force state=IDLE, idx=0, carry=0, and busy, done, result, cout, ovf and zero to 0, regardless of state.
REQ-035 Reset mid-RUN SHALL abandon the operation without a done pulse; the first start after release SHALL complete normally.

Verification
REQ-036 add 0x00000001 + 0xFFFFFFFF -> result 0x00000000, cout 1, zero 1, ovf 0, done 9 cycles after acceptance.
REQ-037 add 0x7FFFFFFF + 0x00000001 -> result 0x80000000, ovf 1, cout 0, zero 0.
REQ-038 sub 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, cout 0, ovf 0; sub 0x80000000 - 0x00000001 -> 0x7FFFFFFF, ovf 1, cout 1.
REQ-039 start with new operands pulsed during RUN -> ignored; the first operation's result and a single done pulse are produced.
REQ-040 clear_n low for one cycle at RUN idx=3 -> busy 0, result 0, no done; a subsequent 0x12345678 + 0x11111111 -> 0x23456789.
REQ-041 start held high for 40 cycles -> done pulses spaced exactly 10 cycles apart; slice_* are 0 in every IDLE/DONE cycle.
